id_stage_pipe: RTL and testbench

Parametrised decode stage for the MIPS pipeline: splits the fetched instruction, reads a built-in register file with write-back-to-decode bypass, and registers the decoded bundle into an ID/EX pipeline register with valid/ready handshake. It adds load-use interlock (one-bubble stall) and branch/jump flush. It sits between IF and EX, and receives the WB write port and the controller's decoded control signals.

---
 rtl/id_stage_pipe.sv | 159 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage. Splits the fetched instruction, reads a
// built-in register file (with optional WB->ID bypass), detects the load-use
// hazard and registers the decoded bundle into the ID/EX pipeline register.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. valid never depends on ready from the same side; the
// ID/EX register only changes when it is empty or being drained (adv).
module id_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_NUM   = 32,
    parameter bit BYPASS_EN = 1'b1,
    localparam int AW       = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    // IF side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    // write-back port
    input  logic              wb_w_ena,
    input  logic [AW-1:0]     wb_w_addr,
    input  logic [DATA_W-1:0] wb_w_data,
    // controller
    output logic [5:0]        op,
    output logic [5:0]        func,
    input  logic              w_dst_sel,
    input  logic              w_reg_ena,
    input  logic              rt_sel,
    input  logic              wb_sel,
    input  logic [3:0]        alu_sel,
    input  logic [3:0]        w_mem_ena,
    // ID/EX register
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_rs,
    output logic [AW-1:0]     out_rt,
    output logic [AW-1:0]     out_dst,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [15:0]       out_imme,
    output logic [25:0]       out_j_imme,
    output logic              out_mem_r,
    output logic              out_branch_op,
    output logic              out_j_op,
    output logic              out_w_reg_ena,
    output logic              out_rt_sel,
    output logic              out_wb_sel,
    output logic [3:0]        out_alu_sel,
    output logic [3:0]        out_w_mem_ena,
    output logic              stall
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] rf [REG_NUM];
    logic              rt_used;
    logic              hazard;
    logic              adv;

    // Field split; register fields are truncated to the register address width.
    assign op   = instr[31:26];
    assign func = instr[5:0];
    assign rs   = instr[21 +: AW];
    assign rt   = instr[16 +: AW];
    assign rd   = instr[11 +: AW];

    // Register file write port; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf <= '{default: '0};
        end else if (wb_w_ena && (wb_w_addr != '0)) begin
            rf[wb_w_addr] <= wb_w_data;
        end
    end

    // rs read port: r0 forced to zero, same-cycle WB write forwarded when enabled.
    always_comb begin
        rs_data = rf[rs];
        if (rs == '0) begin
            rs_data = '0;
        end else if (BYPASS_EN && wb_w_ena && (wb_w_addr == rs)) begin
            rs_data = wb_w_data;
        end
    end

    // rt read port: same rules as rs.
    always_comb begin
        rt_data = rf[rt];
        if (rt == '0) begin
            rt_data = '0;
        end else if (BYPASS_EN && wb_w_ena && (wb_w_addr == rt)) begin
            rt_data = wb_w_data;
        end
    end

    // rt is only a real source when it feeds the ALU or supplies store data.
    assign rt_used  = (rt_sel == 1'b0) || (w_mem_ena != 4'd0);
    assign hazard   = in_valid && out_valid && out_mem_r && (out_dst != '0) &&
                      ((out_dst == rs) || ((out_dst == rt) && rt_used));
    // A flush discards the dependent instruction, so there is nothing to wait for.
    assign stall    = hazard && !flush;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !stall;

    // ID/EX register: load on accept, bubble on stall/idle/flush, hold on backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_rs        <= '0;
            out_rt        <= '0;
            out_dst       <= '0;
            out_rs_data   <= '0;
            out_rt_data   <= '0;
            out_imme      <= '0;
            out_j_imme    <= '0;
            out_mem_r     <= 1'b0;
            out_branch_op <= 1'b0;
            out_j_op      <= 1'b0;
            out_w_reg_ena <= 1'b0;
            out_rt_sel    <= 1'b0;
            out_wb_sel    <= 1'b0;
            out_alu_sel   <= '0;
            out_w_mem_ena <= '0;
        end else if (adv) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_valid && !stall) begin
                out_valid     <= 1'b1;
                out_rs        <= rs;
                out_rt        <= rt;
                out_dst       <= w_dst_sel ? rt : rd;
                out_rs_data   <= rs_data;
                out_rt_data   <= rt_data;
                out_imme      <= instr[15:0];
                out_j_imme    <= instr[25:0];
                out_mem_r     <= (op == OP_LW);
                out_branch_op <= (op == OP_BEQ);
                out_j_op      <= (op == OP_J);
                out_w_reg_ena <= w_reg_ena;
                out_rt_sel    <= rt_sel;
                out_wb_sel    <= wb_sel;
                out_alu_sel   <= alu_sel;
                out_w_mem_ena <= w_mem_ena;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: drives two decode stages (bypass on / bypass off) with the
// same stimulus. A reference model records every accepted instruction into an
// expected queue; a monitor compares whatever the stages present against it.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imme;
        logic [25:0] j_imme;
        logic        mem_r;
        logic        branch_op;
        logic        j_op;
        logic        w_reg_ena;
        logic        rt_sel;
        logic        wb_sel;
        logic [3:0]  alu_sel;
        logic [3:0]  w_mem_ena;
    } exp_t;

    typedef struct packed {
        exp_t byp;
        exp_t nb;
    } pair_t;

    localparam int PAIR_W = $bits(pair_t);

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus signals ----------------
    logic        in_valid, flush, out_ready, wb_w_ena;
    logic [31:0] instr, wb_w_data;
    logic [4:0]  wb_w_addr;
    logic        w_dst_sel, w_reg_ena, rt_sel, wb_sel;
    logic [3:0]  alu_sel, w_mem_ena;

    // bypass-enabled instance outputs
    logic        in_ready, out_valid, stall;
    logic [5:0]  op, func;
    logic [4:0]  out_rs, out_rt, out_dst;
    logic [31:0] out_rs_data, out_rt_data;
    logic [15:0] out_imme;
    logic [25:0] out_j_imme;
    logic        out_mem_r, out_branch_op, out_j_op, out_w_reg_ena, out_rt_sel, out_wb_sel;
    logic [3:0]  out_alu_sel, out_w_mem_ena;

    // bypass-disabled instance outputs
    logic        nb_in_ready, nb_out_valid, nb_stall;
    logic [5:0]  nb_op, nb_func;
    logic [4:0]  nb_out_rs, nb_out_rt, nb_out_dst;
    logic [31:0] nb_out_rs_data, nb_out_rt_data;
    logic [15:0] nb_out_imme;
    logic [25:0] nb_out_j_imme;
    logic        nb_out_mem_r, nb_out_branch_op, nb_out_j_op, nb_out_w_reg_ena, nb_out_rt_sel, nb_out_wb_sel;
    logic [3:0]  nb_out_alu_sel, nb_out_w_mem_ena;

    id_stage_pipe #(.DATA_W(32), .REG_NUM(32), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
        .op(op), .func(func), .w_dst_sel(w_dst_sel), .w_reg_ena(w_reg_ena), .rt_sel(rt_sel),
        .wb_sel(wb_sel), .alu_sel(alu_sel), .w_mem_ena(w_mem_ena), .out_valid(out_valid),
        .out_ready(out_ready), .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imme(out_imme),
        .out_j_imme(out_j_imme), .out_mem_r(out_mem_r), .out_branch_op(out_branch_op),
        .out_j_op(out_j_op), .out_w_reg_ena(out_w_reg_ena), .out_rt_sel(out_rt_sel),
        .out_wb_sel(out_wb_sel), .out_alu_sel(out_alu_sel), .out_w_mem_ena(out_w_mem_ena),
        .stall(stall)
    );

    id_stage_pipe #(.DATA_W(32), .REG_NUM(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .instr(instr),
        .flush(flush), .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
        .op(nb_op), .func(nb_func), .w_dst_sel(w_dst_sel), .w_reg_ena(w_reg_ena), .rt_sel(rt_sel),
        .wb_sel(wb_sel), .alu_sel(alu_sel), .w_mem_ena(w_mem_ena), .out_valid(nb_out_valid),
        .out_ready(out_ready), .out_rs(nb_out_rs), .out_rt(nb_out_rt), .out_dst(nb_out_dst),
        .out_rs_data(nb_out_rs_data), .out_rt_data(nb_out_rt_data), .out_imme(nb_out_imme),
        .out_j_imme(nb_out_j_imme), .out_mem_r(nb_out_mem_r), .out_branch_op(nb_out_branch_op),
        .out_j_op(nb_out_j_op), .out_w_reg_ena(nb_out_w_reg_ena), .out_rt_sel(nb_out_rt_sel),
        .out_wb_sel(nb_out_wb_sel), .out_alu_sel(nb_out_alu_sel), .out_w_mem_ena(nb_out_w_mem_ena),
        .stall(nb_stall)
    );

    // ---------------- reference model ----------------
    logic [31:0]       ref_rf [32];
    logic              m_valid;   // an instruction sits in ID/EX
    logic              m_load;    // ... and it is a lw
    logic [4:0]        m_dst;     // ... writing this register
    logic [PAIR_W-1:0] exp_q [$];
    logic              drain_chk;
    int unsigned       total;
    int unsigned       bad;

    function automatic logic [31:0] read_f(input logic [4:0] a, input logic byp);
        if (a == 5'd0) return 32'd0;
        if (byp && wb_w_ena && (wb_w_addr == a)) return wb_w_data;
        return ref_rf[a];
    endfunction

    // Load-use rule: the lw in ID/EX produces a register the offered instruction reads.
    function automatic logic exp_stall_f();
        logic [4:0] s_rs;
        logic [4:0] s_rt;
        logic       reads_rt;
        s_rs     = instr[25:21];
        s_rt     = instr[20:16];
        reads_rt = !rt_sel || (w_mem_ena != 4'd0);
        return in_valid && !flush && m_valid && m_load && (m_dst != 5'd0) &&
               ((m_dst == s_rs) || ((m_dst == s_rt) && reads_rt));
    endfunction

    function automatic exp_t build_exp(input logic byp);
        exp_t e;
        e.rs        = instr[25:21];
        e.rt        = instr[20:16];
        e.dst       = w_dst_sel ? instr[20:16] : instr[15:11];
        e.rs_data   = read_f(instr[25:21], byp);
        e.rt_data   = read_f(instr[20:16], byp);
        e.imme      = instr[15:0];
        e.j_imme    = instr[25:0];
        e.mem_r     = (instr[31:26] == 6'b100011);
        e.branch_op = (instr[31:26] == 6'b000100);
        e.j_op      = (instr[31:26] == 6'b000010);
        e.w_reg_ena = w_reg_ena;
        e.rt_sel    = rt_sel;
        e.wb_sel    = wb_sel;
        e.alu_sel   = alu_sel;
        e.w_mem_ena = w_mem_ena;
        return e;
    endfunction

    function automatic pair_t build_pair();
        pair_t p;
        p.byp = build_exp(1'b1);
        p.nb  = build_exp(1'b0);
        return p;
    endfunction

    // Model step: accept / drop / hold, then apply the WB write.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_rf  <= '{default: '0};
            m_valid <= 1'b0;
            m_load  <= 1'b0;
            m_dst   <= 5'd0;
        end else begin
            if (!m_valid || out_ready) begin
                if (flush) begin
                    m_valid <= 1'b0;
                end else if (in_valid && !exp_stall_f()) begin
                    exp_q.push_back(build_pair());
                    m_valid <= 1'b1;
                    m_load  <= (instr[31:26] == 6'b100011);
                    m_dst   <= w_dst_sel ? instr[20:16] : instr[15:11];
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (wb_w_ena && (wb_w_addr != 5'd0)) begin
                ref_rf[wb_w_addr] <= wb_w_data;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    function automatic exp_t act_byp();
        exp_t a;
        a = '{out_rs, out_rt, out_dst, out_rs_data, out_rt_data, out_imme, out_j_imme,
              out_mem_r, out_branch_op, out_j_op, out_w_reg_ena, out_rt_sel, out_wb_sel,
              out_alu_sel, out_w_mem_ena};
        return a;
    endfunction

    function automatic exp_t act_nb();
        exp_t a;
        a = '{nb_out_rs, nb_out_rt, nb_out_dst, nb_out_rs_data, nb_out_rt_data, nb_out_imme,
              nb_out_j_imme, nb_out_mem_r, nb_out_branch_op, nb_out_j_op, nb_out_w_reg_ena,
              nb_out_rt_sel, nb_out_wb_sel, nb_out_alu_sel, nb_out_w_mem_ena};
        return a;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int    rd_ptr;
        logic  prev_rst;
        logic  e_stall;
        pair_t p;
        total  = 0;
        bad    = 0;
        rd_ptr = 0;
        #1;
        prev_rst = rst;
        forever begin
            @(negedge clk or negedge rst);
            if (prev_rst && !rst) begin
                // reset asserted between clock edges: outputs must clear immediately
                prev_rst = 1'b0;
                #1;
                chk("async_reset_valid", {255'd0, out_valid}, 256'd0);
                chk("async_reset_valid_nb", {255'd0, nb_out_valid}, 256'd0);
            end else begin
                prev_rst = rst;
                e_stall  = exp_stall_f();
                chk("stall", {255'd0, stall}, {255'd0, e_stall});
                chk("in_ready", {255'd0, in_ready}, {255'd0, (!m_valid || out_ready) && !e_stall});
                chk("stall_nb", {255'd0, nb_stall}, {255'd0, e_stall});
                chk("in_ready_nb", {255'd0, nb_in_ready}, {255'd0, (!m_valid || out_ready) && !e_stall});
                chk("out_valid", {254'd0, out_valid, nb_out_valid}, {254'd0, m_valid, m_valid});
                chk("op_func", {232'd0, op, func, nb_op, nb_func},
                    {232'd0, instr[31:26], instr[5:0], instr[31:26], instr[5:0]});
                if (!rst) begin
                    chk("reset_fields", {57'd0, act_byp()}, 256'd0);
                    chk("reset_fields_nb", {57'd0, act_nb()}, 256'd0);
                    rd_ptr = exp_q.size();
                end else if (out_valid) begin
                    if (rd_ptr >= exp_q.size()) begin
                        chk("unexpected_output", {57'd0, act_byp()}, 256'd0);
                        chk("unexpected_output_nb", {57'd0, act_nb()}, 256'd0);
                    end else begin
                        p = exp_q[rd_ptr];
                        chk("bundle", {57'd0, act_byp()}, {57'd0, p.byp});
                        chk("bundle_nb", {57'd0, act_nb()}, {57'd0, p.nb});
                        if (out_ready) rd_ptr++;
                    end
                end
                if (drain_chk) begin
                    chk("pending_after_drain", 256'(exp_q.size() - rd_ptr), 256'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wb_w_ena  = 1'b0;
        wb_w_addr = 5'd0;
        wb_w_data = 32'd0;
        instr     = 32'd0;
        w_dst_sel = 1'b0;
        w_reg_ena = 1'b0;
        rt_sel    = 1'b0;
        wb_sel    = 1'b0;
        alu_sel   = 4'd0;
        w_mem_ena = 4'd0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_w_ena  = 1'b1;
        wb_w_addr = a;
        wb_w_data = d;
    endtask

    task automatic issue(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic dsel,
                         input logic tsel);
        in_valid  = 1'b1;
        instr     = {o, s, t, d, 5'd0, f};
        w_dst_sel = dsel;
        rt_sel    = tsel;
        w_reg_ena = 1'b1;
        alu_sel   = 4'd2;
    endtask

    task automatic rand_inputs();
        logic [5:0] op_tab [6];
        op_tab    = '{6'b000000, 6'b100011, 6'b000100, 6'b000010, 6'b001000, 6'b101011};
        in_valid  = ($urandom_range(0, 9) < 8);
        instr     = {op_tab[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
        flush     = ($urandom_range(0, 9) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        wb_w_ena  = ($urandom_range(0, 1) == 1);
        wb_w_addr = 5'($urandom_range(0, 7));
        wb_w_data = $urandom;
        w_dst_sel = 1'($urandom_range(0, 1));
        w_reg_ena = 1'($urandom_range(0, 1));
        rt_sel    = 1'($urandom_range(0, 1));
        wb_sel    = 1'($urandom_range(0, 1));
        alu_sel   = 4'($urandom);
        w_mem_ena = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b0;
        drain_chk = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // write r5, then add r3,r5,r0 reads it back
        wb(5'd5, 32'h0000_00AA);
        tick();
        wb_w_ena = 1'b0;
        issue(6'd0, 5'd5, 5'd0, 5'd3, 6'h20, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;

        // same-cycle bypass on r7 (old value 0x55)
        wb(5'd7, 32'h0000_0055);
        tick();
        wb(5'd7, 32'h0000_1234);
        issue(6'd0, 5'd7, 5'd0, 5'd8, 6'h25, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;

        // r0 ignores writes
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        wb_w_ena = 1'b0;
        issue(6'd0, 5'd0, 5'd0, 5'd9, 6'h20, 1'b0, 1'b0);
        tick();

        // lw r4,0(r1) then add r6,r4,r2: one stall cycle then accept
        issue(6'b100011, 5'd1, 5'd4, 5'd0, 6'd0, 1'b1, 1'b1);
        tick();
        issue(6'd0, 5'd4, 5'd2, 5'd6, 6'h20, 1'b0, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        tick();

        // lw r4 then addi reading only rt=4 as its destination: no stall
        issue(6'b100011, 5'd1, 5'd4, 5'd0, 6'd0, 1'b1, 1'b1);
        tick();
        issue(6'b001000, 5'd0, 5'd4, 5'd0, 6'd5, 1'b1, 1'b1);
        tick();

        // backpressure for three cycles, then release
        issue(6'd0, 5'd1, 5'd2, 5'd10, 6'h20, 1'b0, 1'b0);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();

        // flush drops the offered instruction
        issue(6'd0, 5'd3, 5'd3, 5'd11, 6'h20, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();

        // randomized traffic
        repeat (1500) begin
            rand_inputs();
            tick();
        end

        // guarantee an occupied ID/EX register, then reset mid-cycle
        issue(6'd0, 5'd0, 5'd0, 5'd12, 6'h20, 1'b0, 1'b0);
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        #2 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        repeat (300) begin
            rand_inputs();
            tick();
        end

        // drain and confirm every expected instruction came out
        idle_inputs();
        repeat (4) tick();
        drain_chk = 1'b1;
        tick();
        drain_chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
